log2_approx_pipe: RTL and testbench

Multi-lane, parametrised, fully pipelined base-2 logarithm approximator for signed fixed-point operands, the next generation of the stage-1 log2 unit in the softmax approximation tree. Each accepted beat carries LANES operands that share one valid/ready handshake. Each lane produces a Mitchell log2 estimate in the same Q format as its input, plus the raw operand delayed to stay aligned with the result. An optional piecewise-linear correction reduces the Mitchell error.

---
 rtl/log2_approx_pipe.sv | 146 ++++++++++++++
 tb/tb_log2_approx_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe: LANES-wide, two-stage Mitchell log2 of signed fixed-point operands (FRAC_W fraction bits).
// Optional feature macro: LOG2_CORR_EN adds a piecewise-linear mantissa correction in stage 2.
module log2_approx_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10,
    parameter int LANES  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [LANES*DATA_W-1:0]   i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LANES*DATA_W-1:0]   o_log2,
    output logic [LANES*DATA_W-1:0]   o_byp,
    output logic [LANES-1:0]          o_inv
);

    localparam int POS_W  = $clog2(DATA_W);
    localparam int INT_W  = DATA_W - FRAC_W;
    localparam int SINT_W = DATA_W - FRAC_W - 1;

    // The integer part p - FRAC_W spans -FRAC_W .. DATA_W-2-FRAC_W and must fit SINT_W signed bits.
    generate
        if (SINT_W < 1 || FRAC_W < 1) begin : g_cfg_width_err
            $error("log2_approx_pipe: DATA_W/FRAC_W leave no integer bits");
        end else if ((FRAC_W > (1 << (SINT_W - 1))) ||
                     ((DATA_W - 2 - FRAC_W) > ((1 << (SINT_W - 1)) - 1))) begin : g_cfg_range_err
            $error("log2_approx_pipe: integer part range does not fit DATA_W-FRAC_W-1 signed bits");
        end
    endgenerate

    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_adv;
    logic s2_adv;
    logic s1_load;
    logic s2_load;

    assign s2_adv  = !s2_valid_reg || i_ready;
    assign s1_adv  = !s1_valid_reg || s2_adv;
    assign s1_load = i_en && s1_adv;
    assign s2_load = i_en && s2_adv;
    assign o_ready = i_rst_n && i_en && s1_adv;
    assign o_valid = s2_valid_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= i_valid;
            end
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] op;
        logic [POS_W-1:0]  pos_next;
        logic              inv_next;

        logic [DATA_W-1:0] s1_data_reg;
        logic [POS_W-1:0]  s1_pos_reg;
        logic              s1_inv_reg;

        logic [DATA_W-2:0] norm;
        logic [FRAC_W-1:0] mant;
        logic [FRAC_W:0]   mant_fin;
        logic [INT_W-1:0]  int_part;
        logic [DATA_W-1:0] log2_next;

        logic [DATA_W-1:0] s2_log2_reg;
        logic [DATA_W-1:0] s2_byp_reg;
        logic              s2_inv_reg;

        assign op = i_data[gi*DATA_W +: DATA_W];

        // Leading-one detect over the magnitude bits; the sign bit only feeds the invalid flag.
        always_comb begin
            pos_next = '0;
            for (int b = 0; b < DATA_W - 1; b++) begin
                if (op[b]) begin
                    pos_next = POS_W'(b);
                end
            end
        end

        assign inv_next = (op == '0) || op[DATA_W-1];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s1_data_reg <= '0;
                s1_pos_reg  <= '0;
                s1_inv_reg  <= 1'b0;
            end else if (s1_load && i_valid) begin
                s1_data_reg <= op;
                s1_pos_reg  <= pos_next;
                s1_inv_reg  <= inv_next;
            end
        end

        // Shifting the leading one out of the top leaves the fraction left-aligned and zero-filled.
        assign norm     = s1_data_reg[DATA_W-2:0] << (POS_W'(DATA_W - 1) - s1_pos_reg);
        assign mant     = FRAC_W'(norm >> (DATA_W - 1 - FRAC_W));
        assign int_part = INT_W'(s1_pos_reg) - INT_W'(FRAC_W);

`ifdef LOG2_CORR_EN
        logic [FRAC_W:0]   corr_base;
        logic [FRAC_W+2:0] corr_x3;

        // Correction term is 3/16 of the distance to the nearer end of the mantissa interval.
        assign corr_base = mant[FRAC_W-1] ? ({1'b1, {FRAC_W{1'b0}}} - {1'b0, mant})
                                          : {1'b0, mant};
        assign corr_x3   = {2'b00, corr_base} + {1'b0, corr_base, 1'b0};
        assign mant_fin  = {1'b0, mant} + (FRAC_W+1)'(corr_x3 >> 4);
`else
        assign mant_fin  = {1'b0, mant};
`endif

        assign log2_next = s1_inv_reg ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : ({int_part, {FRAC_W{1'b0}}} + DATA_W'(mant_fin));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s2_log2_reg <= '0;
                s2_byp_reg  <= '0;
                s2_inv_reg  <= 1'b0;
            end else if (s2_load && s1_valid_reg) begin
                s2_log2_reg <= log2_next;
                s2_byp_reg  <= s1_data_reg;
                s2_inv_reg  <= s1_inv_reg;
            end
        end

        assign o_log2[gi*DATA_W +: DATA_W] = s2_log2_reg;
        assign o_byp[gi*DATA_W +: DATA_W]  = s2_byp_reg;
        assign o_inv[gi]                   = s2_inv_reg;
    end

endmodule

// File: tb/tb_log2_approx_pipe.sv
// Self-checking bench for log2_approx_pipe: fixed vectors, streaming, stall, enable, reset and random traffic.
// Expected results come from a plain-arithmetic log2 model; define LOG2_CORR_EN to match a corrected build.
module tb_log2_approx_pipe;

    localparam int DW = 16;
    localparam int FW = 10;
    localparam int LN = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_en;
    logic                 i_valid;
    logic                 o_ready;
    logic [LN*DW-1:0]     i_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [LN*DW-1:0]     o_log2;
    logic [LN*DW-1:0]     o_byp;
    logic [LN-1:0]        o_inv;

    int checks   = 0;
    int failures = 0;
    int beat_no  = 0;

    logic [LN*DW-1:0] exp_q[$];
    logic             pend_hold = 1'b0;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [LN-1:0] inv;
    } vec_t;

    vec_t vec[8];

    always #5 i_clk = ~i_clk;

    log2_approx_pipe #(
        .DATA_W(DW),
        .FRAC_W(FW),
        .LANES (LN)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_en),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_log2 (o_log2),
        .o_byp  (o_byp),
        .o_inv  (o_inv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic ref_inv(input logic [DW-1:0] x);
        return (x == '0) || x[DW-1];
    endfunction

    // log2(x / 2^FW) ~= p - FW + (x - 2^p) / 2^p, with the fraction truncated to FW bits.
    function automatic logic [DW-1:0] ref_log2(input logic [DW-1:0] x);
        longint v;
        longint m;
        longint corr;
        longint r;
        int     p;
        if (ref_inv(x)) return {1'b1, {(DW-1){1'b0}}};
        v = longint'(x);
        p = 0;
        while ((longint'(1) << (p + 1)) <= v) p++;
        m = ((v - (longint'(1) << p)) << FW) / (longint'(1) << p);
        corr = 0;
`ifdef LOG2_CORR_EN
        if (m < (longint'(1) << (FW - 1))) corr = (3 * m) / 16;
        else                               corr = (3 * ((longint'(1) << FW) - m)) / 16;
`endif
        r = longint'(p - FW) * (longint'(1) << FW) + m + corr;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_op();
        int unsigned   sel = $urandom_range(0, 7);
        logic [DW-1:0] v   = DW'($urandom);
        case (sel)
            0:       v = '0;
            1:       v[DW-1] = 1'b1;
            2:       v = DW'($urandom_range(1, 15));
            default: v[DW-1] = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [LN*DW-1:0] rnd_beat();
        logic [LN*DW-1:0] b;
        for (int k = 0; k < LN; k++) b[k*DW +: DW] = rnd_op();
        return b;
    endfunction

    // Scoreboard: accepted beats queue up; the visible output must always match the oldest one.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            pend_hold = 1'b0;
        end else begin
            if (pend_hold) check("hold_valid", o_valid, 1);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_beat actual=o_valid_1 required=no_beat_pending");
                end else begin
                    for (int k = 0; k < LN; k++) begin
                        logic [DW-1:0] x;
                        x = exp_q[0][k*DW +: DW];
                        check($sformatf("log2_lane%0d", k), o_log2[k*DW +: DW], ref_log2(x));
                        check($sformatf("byp_lane%0d", k), o_byp[k*DW +: DW], x);
                        check($sformatf("inv_lane%0d", k), o_inv[k], ref_inv(x));
                    end
                end
            end
            if (o_valid && i_ready && i_en && exp_q.size() > 0) begin
                $display("beat %0d: byp=%h log2=%h inv=%b", beat_no, o_byp, o_log2, o_inv);
                void'(exp_q.pop_front());
                beat_no++;
            end
            if (i_valid && o_ready) exp_q.push_back(i_data);
            pend_hold = o_valid && !(i_ready && i_en);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=no_finish required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int               lat;
        int               n;
        logic             acc;
        logic [LN*DW-1:0] d;

        vec[0] = '{d0:16'h0400, d1:16'h0400, e0:16'h0000, e1:16'h0000, inv:2'b00};
        vec[1] = '{d0:16'h0800, d1:16'h0400, e0:16'h0400, e1:16'h0000, inv:2'b00};
        vec[2] = '{d0:16'h0200, d1:16'h0400, e0:16'hFC00, e1:16'h0000, inv:2'b00};
        vec[3] = '{d0:16'h0001, d1:16'h0400, e0:16'hD800, e1:16'h0000, inv:2'b00};
        vec[4] = '{d0:16'h7FFF, d1:16'h0400, e0:16'h13FF, e1:16'h0000, inv:2'b00};
`ifdef LOG2_CORR_EN
        vec[5] = '{d0:16'h0600, d1:16'h0C00, e0:16'h0260, e1:16'h0660, inv:2'b00};
        vec[6] = '{d0:16'h0300, d1:16'h7FFF, e0:16'hFE60, e1:16'h13FF, inv:2'b00};
`else
        vec[5] = '{d0:16'h0600, d1:16'h0C00, e0:16'h0200, e1:16'h0600, inv:2'b00};
        vec[6] = '{d0:16'h0300, d1:16'h7FFF, e0:16'hFE00, e1:16'h13FF, inv:2'b00};
`endif
        vec[7] = '{d0:16'h0000, d1:16'hFC00, e0:16'h8000, e1:16'h8000, inv:2'b11};

        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("ready_in_reset", o_ready, 0);
        check("valid_in_reset", o_valid, 0);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        check("reset_valid", o_valid, 0);
        check("reset_log2", o_log2, 0);
        check("reset_byp", o_byp, 0);
        check("reset_inv", o_inv, 0);
        check("ready_after_reset", o_ready, 1);

        // Fixed vectors, one beat at a time, with latency measured from the accepting edge.
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b1;
            i_data  = {vec[i].d1, vec[i].d0};
            @(negedge i_clk);
            check("tbl_ready", o_ready, 1);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            @(negedge i_clk);
            lat = 1;
            while (!o_valid && lat < 10) begin
                @(negedge i_clk);
                lat++;
            end
            check("tbl_latency", lat, 2);
            check("tbl_log2", o_log2, {vec[i].e1, vec[i].e0});
            check("tbl_inv", o_inv, vec[i].inv);
            check("tbl_byp", o_byp, {vec[i].d1, vec[i].d0});
            $display("vec %0d: in=%h log2=%h inv=%b", i, i_data, o_log2, o_inv);
        end

        // Back-to-back stream of 20 beats.
        @(posedge i_clk); #1;
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                i_valid = 1'b1;
                i_data  = rnd_beat();
            end else begin
                i_valid = 1'b0;
            end
            @(negedge i_clk);
            if (c < 20) check("stream_ready", o_ready, 1);
            check("stream_valid", o_valid, (c >= 2 && c <= 21));
            @(posedge i_clk); #1;
        end

        // Downstream stall from an empty pipe: two beats fill it, then o_ready drops.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = rnd_beat();
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            acc = o_ready;
            check("stall_ready", o_ready, (c < 2));
            @(posedge i_clk); #1;
            if (acc) i_data = rnd_beat();
        end
        i_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            acc = o_ready;
            check("release_ready", o_ready, 1);
            @(posedge i_clk); #1;
            if (acc) i_data = rnd_beat();
        end
        i_valid = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end

        // Global enable low for three cycles mid-stream.
        i_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_data = rnd_beat();
            @(posedge i_clk); #1;
        end
        i_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("en_ready", o_ready, 0);
            check("en_valid", o_valid, 1);
            @(posedge i_clk); #1;
        end
        i_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_data = rnd_beat();
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end

        // Asynchronous reset mid-stream flushes everything in flight.
        i_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_data = rnd_beat();
            @(posedge i_clk); #1;
        end
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_async_valid", o_valid, 0);
        check("rst_async_ready", o_ready, 0);
        i_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        d = {16'h0C00, 16'h0600};
        i_valid = 1'b1;
        i_data  = d;
        @(negedge i_clk);
        check("rst_accept_ready", o_ready, 1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        n = 0;
        @(negedge i_clk);
        while (!o_valid && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        check("rst_first_valid", o_valid, 1);
        check("rst_first_byp", o_byp, d);
        check("rst_first_log2", o_log2, {ref_log2(d[2*DW-1:DW]), ref_log2(d[DW-1:0])});
        @(posedge i_clk); #1;

        // Random traffic with random enable and backpressure.
        acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            i_en    = ($urandom_range(0, 9) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            if (!i_valid || acc) begin
                i_valid = ($urandom_range(0, 2) != 0);
                i_data  = rnd_beat();
            end
            @(negedge i_clk);
            acc = i_valid && o_ready;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_en    = 1'b1;
        i_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(negedge i_clk);
        check("drain_valid", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
